// File: rtl/atm_pkg.sv
// atm_pkg: state encodings and menu option codes shared by the ATM session controller
package atm_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_PIN  = 3'b001,
    S_MENU = 3'b010,
    S_BAL  = 3'b011,
    S_WDR  = 3'b100,
    S_DEP  = 3'b101,
    S_EJ   = 3'b110,
    S_LOCK = 3'b111
  } state_t;
  localparam logic [1:0] OPT_EXIT = 2'b00;
  localparam logic [1:0] OPT_BAL  = 2'b01;
  localparam logic [1:0] OPT_WDR  = 2'b10;
  localparam logic [1:0] OPT_DEP  = 2'b11;
endpackage

// File: rtl/atm_idle_timer.sv
// atm_idle_timer: inactivity counter that saturates at TIMEOUT and flags terminal count
module atm_idle_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  assign tc = cnt == TW'(TIMEOUT);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card session FSM with PIN retry lockout, idle timeout and balance register
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int BAL_W     = 16,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 255,
  parameter int INIT_BAL  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card,
  input  logic             pin_ok,
  input  logic             pin_bad,
  input  logic [1:0]       opt,
  input  logic             sel,
  input  logic [BAL_W-1:0] amt,
  input  logic             amt_vld,
  output logic [2:0]       state,
  output logic [BAL_W-1:0] bal,
  output logic             show_bal,
  output logic             dispense,
  output logic             accept,
  output logic             err,
  output logic             eject,
  output logic             lock
);
  state_t st, st_nx;
  logic [2:0] tries;
  logic [2:0] tries_inc;
  logic [BAL_W:0] sum;
  logic tc, clr, en, bad, live, wdr_go, dep_go, wdr_ok, dep_ok;
  assign tries_inc = tries + 3'd1;
  assign bad = pin_bad;
  assign sum = {1'b0, bal} + {1'b0, amt};
  // live: card still present and the idle timer has not fired, so events may act
  assign live = card && !tc;
  assign wdr_go = st == S_WDR && live && amt_vld;
  assign dep_go = st == S_DEP && live && amt_vld;
  assign wdr_ok = amt != '0 && amt <= bal;
  assign dep_ok = amt != '0 && !sum[BAL_W];
  assign en = st inside {S_PIN, S_MENU, S_WDR, S_DEP};
  assign clr = st_nx != st || pin_ok || pin_bad || sel || amt_vld;
  atm_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .tc (tc)
  );
  always_ff @(posedge clk)
    if (rst) st <= S_IDLE;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE: st_nx = card ? S_PIN : S_IDLE;
      S_PIN:  st_nx = !card ? S_IDLE : tc ? S_EJ :
                      bad ? (tries_inc == 3'(MAX_TRIES) ? S_LOCK : S_PIN) :
                      pin_ok ? S_MENU : S_PIN;
      S_MENU: st_nx = !card ? S_IDLE : tc ? S_EJ : !sel ? S_MENU :
                      opt == OPT_BAL ? S_BAL : opt == OPT_WDR ? S_WDR :
                      opt == OPT_DEP ? S_DEP : S_EJ;
      S_BAL:  st_nx = card ? S_MENU : S_IDLE;
      S_WDR,
      S_DEP:  st_nx = !card ? S_IDLE : tc ? S_EJ : amt_vld ? S_MENU : st;
      S_EJ:   st_nx = card ? S_EJ : S_IDLE;
      S_LOCK: st_nx = S_LOCK;
    endcase
  end
  always_comb begin
    state    = st;
    show_bal = st == S_BAL;
    eject    = st == S_EJ;
    lock     = st == S_LOCK;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bal      <= BAL_W'(INIT_BAL);
      tries    <= '0;
      dispense <= 1'b0;
      accept   <= 1'b0;
      err      <= 1'b0;
    end else begin
      bal      <= wdr_go && wdr_ok ? bal - amt : dep_go && dep_ok ? sum[BAL_W-1:0] : bal;
      tries    <= st == S_IDLE && card ? '0 : st == S_PIN && live && bad ? tries_inc : tries;
      dispense <= wdr_go && wdr_ok;
      accept   <= dep_go && dep_ok;
      err      <= (wdr_go && !wdr_ok) || (dep_go && !dep_ok);
    end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: scenario tasks plus randomized transactions against a balance model
module tb_atm_session_ctrl;
  logic clk = 1'b0, rst, card, pin_ok, pin_bad, sel, amt_vld;
  logic [1:0] opt;
  logic [15:0] amt, bal;
  logic [2:0] state;
  logic show_bal, dispense, accept, err, eject, lock;
  int checks = 0, passes = 0, model_bal = 1000;

  atm_session_ctrl dut (
    .clk(clk), .rst(rst), .card(card), .pin_ok(pin_ok), .pin_bad(pin_bad),
    .opt(opt), .sel(sel), .amt(amt), .amt_vld(amt_vld), .state(state), .bal(bal),
    .show_bal(show_bal), .dispense(dispense), .accept(accept), .err(err),
    .eject(eject), .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic choose(input logic [1:0] o);
    opt = o; sel = 1'b1; tick; sel = 1'b0;
  endtask

  task automatic txn(input logic [15:0] a);
    amt = a; amt_vld = 1'b1; tick; amt_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    checks++; if ({state, bal} !== {3'b000, 16'd1000}) $display("FAIL reset state/bal got %b/%0d want 000/1000", state, bal); else passes++;
    checks++; if ({show_bal, dispense, accept, err, eject, lock} !== 6'b0) $display("FAIL reset outs got %b want 000000", {show_bal, dispense, accept, err, eject, lock}); else passes++;
    rst = 1'b0; tick;
  endtask

  task automatic test_balance;
    card = 1'b1; tick;
    checks++; if (state !== 3'b001) $display("FAIL card_in state got %b want 001", state); else passes++;
    pin_ok = 1'b1; tick; pin_ok = 1'b0;
    checks++; if (state !== 3'b010) $display("FAIL pin_ok state got %b want 010", state); else passes++;
    choose(2'b01);
    checks++; if ({state, show_bal} !== {3'b011, 1'b1}) $display("FAIL balance got %b/%b want 011/1", state, show_bal); else passes++;
    tick;
    checks++; if ({state, show_bal, bal} !== {3'b010, 1'b0, 16'd1000}) $display("FAIL balance_exit got %b/%b/%0d want 010/0/1000", state, show_bal, bal); else passes++;
  endtask

  task automatic test_withdraw;
    txn(16'd5);
    checks++; if ({state, bal, dispense, accept, err} !== {3'b010, 16'd1000, 3'b000}) $display("FAIL menu_ignores_amt got %b/%0d/%b", state, bal, {dispense, accept, err}); else passes++;
    choose(2'b10);
    checks++; if (state !== 3'b100) $display("FAIL wdr_enter got %b want 100", state); else passes++;
    txn(16'd300);
    checks++; if ({state, bal, dispense, err} !== {3'b010, 16'd700, 2'b10}) $display("FAIL wdr_300 got %b/%0d/%b want 010/700/10", state, bal, {dispense, err}); else passes++;
    tick;
    checks++; if (dispense !== 1'b0) $display("FAIL dispense_one_cycle got %b want 0", dispense); else passes++;
    choose(2'b10); txn(16'd701);
    checks++; if ({bal, dispense, err} !== {16'd700, 2'b01}) $display("FAIL wdr_701 got %0d/%b want 700/01", bal, {dispense, err}); else passes++;
    choose(2'b10); txn(16'd0);
    checks++; if ({bal, dispense, err} !== {16'd700, 2'b01}) $display("FAIL wdr_zero got %0d/%b want 700/01", bal, {dispense, err}); else passes++;
    tick;
    checks++; if (err !== 1'b0) $display("FAIL err_one_cycle got %b want 0", err); else passes++;
  endtask

  task automatic test_deposit;
    choose(2'b11);
    checks++; if (state !== 3'b101) $display("FAIL dep_enter got %b want 101", state); else passes++;
    txn(16'd64300);
    checks++; if ({bal, accept, err} !== {16'd65000, 2'b10}) $display("FAIL dep_64300 got %0d/%b want 65000/10", bal, {accept, err}); else passes++;
    choose(2'b11); txn(16'd600);
    checks++; if ({bal, accept, err} !== {16'd65000, 2'b01}) $display("FAIL dep_carry got %0d/%b want 65000/01", bal, {accept, err}); else passes++;
    choose(2'b11); txn(16'd500);
    checks++; if ({bal, accept, err} !== {16'd65500, 2'b10}) $display("FAIL dep_500 got %0d/%b want 65500/10", bal, {accept, err}); else passes++;
    choose(2'b11); txn(16'd35);
    checks++; if ({bal, accept, err} !== {16'd65535, 2'b10}) $display("FAIL dep_to_max got %0d/%b want 65535/10", bal, {accept, err}); else passes++;
    choose(2'b11); txn(16'd1);
    checks++; if ({state, bal, accept, err} !== {3'b010, 16'd65535, 2'b01}) $display("FAIL dep_max_plus1 got %b/%0d/%b", state, bal, {accept, err}); else passes++;
    model_bal = 65535;
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      bit wdr;
      bit ok;
      int a;
      int r;
      wdr = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 3);
      a = r == 0 ? 0 : r == 1 ? $urandom_range(1, 50) : r == 2 ? $urandom_range(0, 65535) :
          (wdr ? model_bal + $urandom_range(0, 2) - 1 : 65535 - model_bal + $urandom_range(0, 2) - 1);
      if (a < 0) a = 0;
      if (a > 65535) a = 65535;
      ok = a != 0 && (wdr ? a <= model_bal : model_bal + a <= 65535);
      choose(wdr ? 2'b10 : 2'b11);
      repeat ($urandom_range(0, 20)) tick;
      txn(16'(a));
      if (ok) model_bal = wdr ? model_bal - a : model_bal + a;
      checks++; if ({dispense, accept, err} !== {wdr && ok, !wdr && ok, !ok}) $display("FAIL rnd%0d pulses amt=%0d got %b want %b", i, a, {dispense, accept, err}, {wdr && ok, !wdr && ok, !ok}); else passes++;
      checks++; if ({state, bal} !== {3'b010, 16'(model_bal)}) $display("FAIL rnd%0d state/bal got %b/%0d want 010/%0d", i, state, bal, model_bal); else passes++;
      tick;
    end
  endtask

  task automatic test_card_pull;
    choose(2'b10);
    card = 1'b0; amt = 16'd100; amt_vld = 1'b1; tick; amt_vld = 1'b0;
    checks++; if ({state, dispense, err, bal} !== {3'b000, 2'b00, 16'(model_bal)}) $display("FAIL card_pull got %b/%b/%0d want 000/00/%0d", state, {dispense, err}, bal, model_bal); else passes++;
    tick;
    checks++; if ({state, dispense, bal} !== {3'b000, 1'b0, 16'(model_bal)}) $display("FAIL card_pull_after got %b/%b/%0d", state, dispense, bal); else passes++;
  endtask

  task automatic test_lockout;
    card = 1'b1; tick;
    for (int k = 0; k < 2; k++) begin
      pin_bad = 1'b1; tick; pin_bad = 1'b0;
      checks++; if ({state, lock} !== {3'b001, 1'b0}) $display("FAIL bad_pin%0d got %b/%b want 001/0", k, state, lock); else passes++;
    end
    pin_ok = 1'b1; pin_bad = 1'b1; tick; pin_ok = 1'b0; pin_bad = 1'b0;
    checks++; if ({state, lock} !== {3'b111, 1'b1}) $display("FAIL lockout got %b/%b want 111/1", state, lock); else passes++;
    card = 1'b0; pin_ok = 1'b1; tick; pin_ok = 1'b0; tick; tick;
    checks++; if ({state, lock, eject} !== {3'b111, 2'b10}) $display("FAIL lock_holds got %b/%b/%b want 111/1/0", state, lock, eject); else passes++;
    rst = 1'b1; tick; rst = 1'b0;
    model_bal = 1000;
    checks++; if ({state, lock, bal} !== {3'b000, 1'b0, 16'd1000}) $display("FAIL lock_reset got %b/%b/%0d want 000/0/1000", state, lock, bal); else passes++;
  endtask

  task automatic test_timeout;
    card = 1'b1; tick;
    pin_bad = 1'b1; tick; tick; pin_bad = 1'b0;
    pin_ok = 1'b1; tick; pin_ok = 1'b0;
    checks++; if (state !== 3'b010) $display("FAIL tries_cleared got %b want 010", state); else passes++;
    repeat (200) tick;
    pin_ok = 1'b1; tick; pin_ok = 1'b0;
    repeat (255) tick;
    checks++; if ({state, eject} !== {3'b010, 1'b0}) $display("FAIL before_timeout got %b/%b want 010/0", state, eject); else passes++;
    tick;
    checks++; if ({state, eject} !== {3'b110, 1'b1}) $display("FAIL timeout got %b/%b want 110/1", state, eject); else passes++;
    tick; tick;
    checks++; if ({state, eject} !== {3'b110, 1'b1}) $display("FAIL eject_hold got %b/%b want 110/1", state, eject); else passes++;
    card = 1'b0; tick;
    checks++; if ({state, eject, bal} !== {3'b000, 1'b0, 16'(model_bal)}) $display("FAIL eject_done got %b/%b/%0d", state, eject, bal); else passes++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; card = 1'b0; pin_ok = 1'b0; pin_bad = 1'b0; sel = 1'b0; amt_vld = 1'b0;
    opt = 2'b00; amt = 16'd0;
    test_reset;
    test_balance;
    test_withdraw;
    test_deposit;
    test_random;
    test_card_pull;
    test_lockout;
    test_timeout;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
